robs_control: RTL and testbench
===============================

Name: robs_control

Overview:
- FSM sequencer for the Robertson signed-multiplication datapath (robs_datapath).
- Accepts a start request and drives the 15-bit control word c each cycle.
- Consumes the status flags zr (R even) and zq (down-counter q mod 8 == 0).
- Reports busy/done to the top level and flags sequencing errors.

Parameters:
- WIDTH, 8, operand width. Must match the datapath. The zq-based check is meaningful only for WIDTH=8.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin a multiply; sampled only in IDLE
- zr  in  1  datapath R LSB is 0
- zq  in  1  datapath counter q mod 8 == 0
- c  out  15  datapath control word
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; product valid on the datapath product bus
- seq_err  out  1  sticky; zq disagreed with the internal last-iteration flag

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, c=0, busy=0, done=0, seq_err=0, iter=0, last=0. Reset mid-operation aborts immediately; no partial result is flagged.
- c bit map:
  - c0 load Y; c1 counter reset; c2 clear A; c3 load X.
  - c5:4 RH mux select: 0=A, 1=SR high, 2=ALU.
  - c6 RL mux select: 0=X, 1=SR low.
  - c7 X mux select: 0=multiplier, 1=R low.
  - c8 load RH; c9 load RL.
  - c10 add_sub: 1=add, 0=subtract.
  - c11 shift mode: 1=arithmetic.
  - c12 shift enable; c13 counter decrement; c14 load A.
- Unlisted bits are 0 in each state. c is a registered Moore output of the state.
- States and asserted c bits:
  - IDLE: c=0. start=1 -> INIT.
  - INIT: c0,c1,c2,c3 (c7=0); iter<=0 -> LOADR.
  - LOADR: c8,c9 (c5:4=0, c6=0); R<={A,X} -> DEC.
  - DEC: c13 -> TEST.
  - TEST: last<=(iter==WIDTH-1). If zq!=(iter==WIDTH-1), set seq_err. If zr -> SHIFT; else if last -> SUB; else -> ADD.
  - ADD: c5:4=2, c10=1, c8 -> SHIFT.
  - SUB: c5:4=2, c10=0, c8 -> SHIFT.
  - SHIFT: c11,c12 -> WB.
  - WB: c5:4=1, c6=1, c8, c9; iter<=iter+1. If last -> FINAL; else -> DEC.
  - FINAL: c14, c3, c7=1 (A<=R high, X<=R low) -> DONE.
  - DONE: done=1 -> IDLE.
- Latency:
  - Start is sampled at edge 0. Each iteration costs 4 cycles, plus 1 if the multiplier bit is 1.
  - With k = number of 1 bits in the multiplier (WIDTH=8): done is high in cycle 36+k.
- start while busy is ignored, with no queuing. start held high through DONE launches a new multiply directly from IDLE on the next cycle.
- Arithmetic: the last iteration subtracts Y, giving the two's-complement sign weight. Overflow of A±Y before the shift is not detected; the bench avoids the (-128)×(-128) corner.
- The iter counter is $clog2(WIDTH+1) bits. It never wraps within a run because it is cleared in INIT.

Decomposition:
- Package robs_pkg holds:
  - state_t enum: IDLE, INIT, LOADR, DEC, TEST, ADD, SUB, SHIFT, WB, FINAL, DONE.
  - localparam bit indices C_LDY=0 … C_LDA=14.
  - localparams for the RH mux codes RH_A, RH_SR, RH_ALU.
- No sub-module: a single FSM plus the iteration counter.
- The top level instantiates robs_control beside robs_datapath.

Test Plan:
- multiplier=5, multiplicand=3 -> product 0x000F; done at cycle 38 (k=2); seq_err=0.
- multiplier=5, multiplicand=-3 (0xFD) -> product 0xFFF1 (-15).
- multiplier=-2 (0xFE), multiplicand=7 -> SUB state entered exactly once (iteration 8); product 0xFFF2 (-14); done at cycle 43.
- multiplier=0, multiplicand=0x55 -> no ADD/SUB visits; done at cycle 36; product 0x0000.
- Reset pulsed low at cycle 10 of a run -> same cycle: c=0, busy=0, state IDLE; a fresh start then gives 5×3=15 correctly.
- start pulsed again at cycle 20 mid-run -> ignored; exactly one done pulse. Forcing zq=1 in iteration 3's TEST -> seq_err latches to 1 until reset.

Source files
------------

// File: rtl/robs_pkg.sv
// ---------------------------------------------------------------------------
// robs_pkg
// Shared definitions for the Robertson signed-multiplier sequencer:
//   - state_t     : sequencer state encoding
//   - C_*         : bit positions inside the 15-bit datapath control word
//   - RH_*        : select codes for the RH input multiplexer
//   - ctrl_word() : Moore decode of a state into its control word
// ---------------------------------------------------------------------------
package robs_pkg;

   localparam int CW = 15;

   typedef enum logic [3:0] {
      IDLE  = 4'd0,
      INIT  = 4'd1,
      LOADR = 4'd2,
      DEC   = 4'd3,
      TEST  = 4'd4,
      ADD   = 4'd5,
      SUB   = 4'd6,
      SHIFT = 4'd7,
      WB    = 4'd8,
      FINAL = 4'd9,
      DONE  = 4'd10
   } state_t;

   // Control word bit positions
   localparam int C_LDY      = 0;   // load Y (multiplicand)
   localparam int C_QRST     = 1;   // counter reset
   localparam int C_CLRA     = 2;   // clear A
   localparam int C_LDX      = 3;   // load X
   localparam int C_RHSEL_LO = 4;   // RH mux select, low bit
   localparam int C_RHSEL_HI = 5;   // RH mux select, high bit
   localparam int C_RLSEL    = 6;   // RL mux: 0=X, 1=SR low
   localparam int C_XSEL     = 7;   // X mux: 0=multiplier, 1=R low
   localparam int C_LDRH     = 8;   // load RH
   localparam int C_LDRL     = 9;   // load RL
   localparam int C_ADDSUB   = 10;  // ALU: 1=add, 0=subtract
   localparam int C_SHARITH  = 11;  // shift mode: 1=arithmetic
   localparam int C_SHEN     = 12;  // shift enable
   localparam int C_QDEC     = 13;  // counter decrement
   localparam int C_LDA      = 14;  // load A

   // RH multiplexer codes
   localparam logic [1:0] RH_A   = 2'd0;
   localparam logic [1:0] RH_SR  = 2'd1;
   localparam logic [1:0] RH_ALU = 2'd2;

   // Control word asserted while the sequencer sits in state s.
   // States that drive nothing (IDLE, TEST, DONE) fall through to all-zero.
   function automatic logic [CW-1:0] ctrl_word(input state_t s);
      logic [CW-1:0] w;
      w = {CW{1'b0}};
      case (s)
         INIT: begin
            w[C_LDY]  = 1'b1;
            w[C_QRST] = 1'b1;
            w[C_CLRA] = 1'b1;
            w[C_LDX]  = 1'b1;
         end
         LOADR: begin
            w[C_RHSEL_HI:C_RHSEL_LO] = RH_A;
            w[C_LDRH] = 1'b1;
            w[C_LDRL] = 1'b1;
         end
         DEC: begin
            w[C_QDEC] = 1'b1;
         end
         ADD: begin
            w[C_RHSEL_HI:C_RHSEL_LO] = RH_ALU;
            w[C_ADDSUB] = 1'b1;
            w[C_LDRH]   = 1'b1;
         end
         SUB: begin
            w[C_RHSEL_HI:C_RHSEL_LO] = RH_ALU;
            w[C_ADDSUB] = 1'b0;
            w[C_LDRH]   = 1'b1;
         end
         SHIFT: begin
            w[C_SHARITH] = 1'b1;
            w[C_SHEN]    = 1'b1;
         end
         WB: begin
            w[C_RHSEL_HI:C_RHSEL_LO] = RH_SR;
            w[C_RLSEL] = 1'b1;
            w[C_LDRH]  = 1'b1;
            w[C_LDRL]  = 1'b1;
         end
         FINAL: begin
            // A <= R high, X <= R low: the product lands on {A, X}
            w[C_LDA]  = 1'b1;
            w[C_LDX]  = 1'b1;
            w[C_XSEL] = 1'b1;
         end
         default: begin
            w = {CW{1'b0}};
         end
      endcase
      return w;
   endfunction

endpackage

// File: rtl/robs_control.sv
// ---------------------------------------------------------------------------
// robs_control
// Sequencer for the Robertson signed-multiplication datapath. A start request
// in IDLE runs WIDTH iterations of test / (add|sub) / shift / write-back and
// finally moves R into {A, X}, where the product is presented.
//
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous active-low reset
//   start    in   begin a multiply (sampled only in IDLE)
//   zr       in   datapath R LSB is 0
//   zq       in   datapath down-counter q mod 8 == 0
//   c        out  15-bit datapath control word (registered, Moore)
//   busy     out  high in every state except IDLE
//   done     out  one-cycle pulse, product valid on the datapath
//   seq_err  out  sticky: zq disagreed with the internal last-iteration flag
// ---------------------------------------------------------------------------
module robs_control
   import robs_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          zr,
   input  logic          zq,
   output logic [CW-1:0] c,
   output logic          busy,
   output logic          done,
   output logic          seq_err
);

   localparam int            IW        = $clog2(WIDTH + 1);
   localparam logic [IW-1:0] LAST_ITER = IW'(WIDTH - 1);

   state_t        state_r;
   state_t        state_s;
   logic [IW-1:0] iter_r;
   logic [IW-1:0] iter_s;
   logic          last_r;
   logic          last_s;
   logic          err_s;
   logic          is_last_s;

   // The current iteration is the final (sign-weight) one
   assign is_last_s = (iter_r == LAST_ITER);

   // Next-state, iteration counter and error-flag logic
   always_comb begin
      state_s = state_r;
      iter_s  = iter_r;
      last_s  = last_r;
      err_s   = seq_err;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_s = INIT;
            end else begin
               state_s = IDLE;
            end
         end
         INIT: begin
            iter_s  = {IW{1'b0}};
            last_s  = 1'b0;
            state_s = LOADR;
         end
         LOADR: begin
            state_s = DEC;
         end
         DEC: begin
            state_s = TEST;
         end
         TEST: begin
            // Routing uses the fresh comparison; last_r only feeds WB.
            last_s = is_last_s;
            // The datapath counter must agree with our own iteration count.
            if (zq != is_last_s) begin
               err_s = 1'b1;
            end else begin
               err_s = seq_err;
            end
            if (zr) begin
               state_s = SHIFT;
            end else if (is_last_s) begin
               state_s = SUB;
            end else begin
               state_s = ADD;
            end
         end
         ADD: begin
            state_s = SHIFT;
         end
         SUB: begin
            state_s = SHIFT;
         end
         SHIFT: begin
            state_s = WB;
         end
         WB: begin
            iter_s = iter_r + IW'(1);
            if (last_r) begin
               state_s = FINAL;
            end else begin
               state_s = DEC;
            end
         end
         FINAL: begin
            state_s = DONE;
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, counter and registered outputs; outputs decode the next state so
   // they line up with the state register cycle for cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
         iter_r  <= {IW{1'b0}};
         last_r  <= 1'b0;
         c       <= {CW{1'b0}};
         busy    <= 1'b0;
         done    <= 1'b0;
         seq_err <= 1'b0;
      end else begin
         state_r <= state_s;
         iter_r  <= iter_s;
         last_r  <= last_s;
         c       <= ctrl_word(state_s);
         busy    <= (state_s != IDLE);
         done    <= (state_s == DONE);
         seq_err <= err_s;
      end
   end

endmodule

// File: tb/tb_robs_control.sv
// ---------------------------------------------------------------------------
// tb_robs_control
// Drives robs_control through a behavioural model of the Robertson datapath
// that reacts to the control word and feeds back zr/zq. Expectations come from
// plain arithmetic: product = a*b, done cycle = 36 + popcount(multiplier),
// ADD visits = popcount of the low 7 multiplier bits, SUB visits = sign bit.
// ---------------------------------------------------------------------------
module tb_robs_control;

   localparam logic [14:0] ADD_W  = 15'h0520;  // c10 | c8 | c5:4=2
   localparam logic [14:0] SUB_W  = 15'h0120;  // c8 | c5:4=2
   localparam logic [14:0] INIT_W = 15'h000F;  // c0..c3

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        zr;
   logic        zq;
   logic [14:0] c;
   logic        busy;
   logic        done;
   logic        seq_err;

   int total = 0;
   int bad   = 0;

   // datapath model state
   logic [7:0] mplier;
   logic [7:0] mcand;
   logic [7:0] y_q;
   logic [7:0] a_q;
   logic [7:0] x_q;
   logic [7:0] rl;
   logic [7:0] sr_l;
   int         rh;
   int         sr_h;
   int         q_cnt;
   logic       force_zq;

   always #5 clk = ~clk;

   robs_control #(.WIDTH(8)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .zr      (zr),
      .zq      (zq),
      .c       (c),
      .busy    (busy),
      .done    (done),
      .seq_err (seq_err)
   );

   // Behavioural datapath: RH is kept as a full integer so the model never
   // overflows; R = {RH, RL}.
   always @(posedge clk) begin
      if (c[0]) y_q <= mcand;
      if (c[1]) q_cnt <= 8;
      else if (c[13]) q_cnt <= q_cnt - 1;
      if (c[14]) a_q <= rh[7:0];
      else if (c[2]) a_q <= 8'h00;
      if (c[3]) x_q <= c[7] ? rl : mplier;
      if (c[12]) begin
         sr_h <= c[11] ? (rh >>> 1) : ((rh & 255) >> 1);
         sr_l <= {rh[0], rl[7:1]};
      end
      if (c[8]) begin
         case (c[5:4])
            2'd0:    rh <= {{24{a_q[7]}}, a_q};
            2'd1:    rh <= sr_h;
            2'd2:    rh <= c[10] ? (rh + {{24{y_q[7]}}, y_q}) : (rh - {{24{y_q[7]}}, y_q});
            default: rh <= rh;
         endcase
      end
      if (c[9]) rl <= c[6] ? sr_l : x_q;
   end

   assign zr = ~rl[0];
   assign zq = ((q_cnt % 8) == 0) || force_zq;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One multiply; optional start re-pulse at cycle restart_at and forced zq
   // in TEST number force_test (0-based). err_exp is the expected sticky flag.
   task automatic run_mul(input logic [7:0] mul, input logic [7:0] mc,
                          input int restart_at, input int force_test, input logic err_exp);
      int          cyc;
      int          adds;
      int          subs;
      int          tests;
      int          done_cyc;
      int          ndone;
      int          p;
      logic [15:0] prod_at_done;
      logic [15:0] prod_exp;
      p        = int'($signed(mul)) * int'($signed(mc));
      prod_exp = p[15:0];
      cyc = 0; adds = 0; subs = 0; tests = 0; done_cyc = -1; ndone = 0;
      prod_at_done = 16'h0000;
      @(negedge clk);
      mplier = mul;
      mcand  = mc;
      start  = 1'b1;
      @(posedge clk);  // edge 0: start sampled
      while ((cyc < 120) && !((done_cyc >= 0) && (cyc >= done_cyc + 3))) begin
         @(negedge clk);
         cyc++;
         start    = (cyc == restart_at);
         force_zq = 1'b0;
         if (busy && !done && (c == 15'h0000)) begin
            if (tests == force_test) force_zq = 1'b1;
            tests++;
         end
         if (c == ADD_W) adds++;
         if (c == SUB_W) subs++;
         if (done) begin
            ndone++;
            if (done_cyc < 0) begin
               done_cyc     = cyc;
               prod_at_done = {a_q, x_q};
            end
         end
      end
      start    = 1'b0;
      force_zq = 1'b0;
      check_eq("done_cycle", done_cyc, 36 + $countones(mul));
      check_eq("done_pulses", ndone, 1);
      check_eq("test_visits", tests, 8);
      check_eq("add_visits", adds, $countones(mul[6:0]));
      check_eq("sub_visits", subs, {31'd0, mul[7]});
      check_eq("product", {16'h0000, prod_at_done}, {16'h0000, prod_exp});
      check_eq("seq_err", {31'd0, seq_err}, {31'd0, err_exp});
      check_eq("idle_after", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int         n;
      logic [7:0] ra;
      logic [7:0] rb;
      reset    = 1'b0;
      start    = 1'b0;
      force_zq = 1'b0;
      mplier   = 8'h00;
      mcand    = 8'h00;
      #12;
      check_eq("rst_c", {17'd0, c}, 32'd0);
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_done", {31'd0, done}, 32'd0);
      check_eq("rst_seq_err", {31'd0, seq_err}, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // directed cases
      run_mul(8'h05, 8'h03, -1, -1, 1'b0);
      run_mul(8'h05, 8'hFD, -1, -1, 1'b0);
      run_mul(8'hFE, 8'h07, -1, -1, 1'b0);
      run_mul(8'h00, 8'h55, -1, -1, 1'b0);
      // start re-pulsed mid-run is ignored
      run_mul(8'h05, 8'h03, 20, -1, 1'b0);

      // randomized operands
      for (int i = 0; i < 8; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         if ((ra == 8'h80) && (rb == 8'h80)) rb = 8'h7F;
         run_mul(ra, rb, -1, -1, 1'b0);
      end

      // reset asserted at cycle 10 of a run
      @(negedge clk);
      mplier = 8'h05;
      mcand  = 8'h03;
      start  = 1'b1;
      @(posedge clk);
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         start = 1'b0;
      end
      check_eq("pre_rst_busy", {31'd0, busy}, 32'd1);
      reset = 1'b0;
      #1;
      check_eq("midrst_c", {17'd0, c}, 32'd0);
      check_eq("midrst_busy", {31'd0, busy}, 32'd0);
      check_eq("midrst_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      run_mul(8'h05, 8'h03, -1, -1, 1'b0);

      // start held high through DONE relaunches from IDLE
      @(negedge clk);
      mplier = 8'h03;
      mcand  = 8'h05;
      start  = 1'b1;
      @(posedge clk);
      n = 0;
      while (!done && (n < 100)) begin
         @(negedge clk);
         n++;
      end
      check_eq("hold_done_cycle", n, 38);
      @(negedge clk);
      check_eq("hold_idle_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      check_eq("hold_relaunch_busy", {31'd0, busy}, 32'd1);
      check_eq("hold_relaunch_c", {17'd0, c}, {17'd0, INIT_W});
      start = 1'b0;
      n = 0;
      while (!done && (n < 100)) begin
         @(negedge clk);
         n++;
      end
      check_eq("hold_second_done", {31'd0, done}, 32'd1);
      check_eq("hold_product", {16'h0000, a_q, x_q}, 32'h0000_000F);

      // zq forced in iteration 3: sticky error until reset
      run_mul(8'h05, 8'h03, -1, 3, 1'b1);
      run_mul(8'h07, 8'h09, -1, -1, 1'b1);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_eq("err_cleared", {31'd0, seq_err}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      run_mul(8'h83, 8'h7F, -1, -1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
